// File: rtl/nabp_image_pkg.sv
// -----------------------------------------------------------------------------
// nabp_image_pkg
// Shared definitions for the image-RAM arbiter:
//   - kImageAddressLength / kCacheDataLength : default image address and pixel
//     widths, used as the ADDR_W / DATA_W parameter defaults.
//   - state_e   : pass-sequencing FSM states (CLEAR is only reachable when the
//                 NABP_IMAGE_CLEAR_EN macro is defined).
//   - sat_add() : signed add clamped to a w-bit two's complement range.
// -----------------------------------------------------------------------------
package nabp_image_pkg;

  localparam int kImageAddressLength = 16;
  localparam int kCacheDataLength    = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Operands arrive sign-extended to 64 bits; the result is clamped to
  // [-2^(w-1), 2^(w-1)-1] so the low w bits hold the saturated value.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/nabp_rr_arbiter.sv
// -----------------------------------------------------------------------------
// nabp_rr_arbiter
// Round-robin arbiter: picks the first requesting lane at or after the
// rotating pointer and then moves the pointer one past the winner. With no
// requests (or en_i low) nothing is granted and the pointer holds.
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset (pointer returns to lane 0)
//   en_i     in   arbitration/update enable
//   req_i    in   NUM_REQ request vector
//   gnt_o    out  NUM_REQ one-hot grant (combinational)
// -----------------------------------------------------------------------------
module nabp_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rr_q;
  logic [PTR_W-1:0] rr_d;
  logic [PTR_W-1:0] cand;
  logic             found;

  // (base + off) mod NUM_REQ, valid for off < NUM_REQ; works for any lane
  // count, not only powers of two.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int               off);
    logic [PTR_W:0] s;
    s = {1'b0, base} + (PTR_W+1)'(off);
    if (s >= (PTR_W+1)'(NUM_REQ)) begin
      s = s - (PTR_W+1)'(NUM_REQ);
    end
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    gnt_o = '0;
    rr_d  = rr_q;
    cand  = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = wrap_add(rr_q, off);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        rr_d        = wrap_add(cand, 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/nabp_image_ram_arbiter.sv
// -----------------------------------------------------------------------------
// nabp_image_ram_arbiter
// Shares the image RAM between NUM_REQ back-projection lanes. One lane is
// granted per cycle (round robin); its (address, increment) pair performs a
// saturating read-modify-write into the RAM: read at grant cycle t, write at
// t+1. A one-entry last-write register forwards the previous cycle's result
// so back-to-back hits on one address accumulate exactly even though the RAM
// returns old data on a same-cycle read/write collision.
// Pass sequencing: IDLE -(kick)-> [CLEAR] -> RUN -(ir_done)-> DRAIN -> DONE.
// Build option: define NABP_IMAGE_CLEAR_EN to zero the whole image after
// every kick before RUN starts; otherwise kick enters RUN directly.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   ir_kick, ir_done      pass start / end pulses
//   req_valid/addr/val    per-lane request (lane i at [i*W +: W])
//   req_ready             one-hot grant
//   ram_rd_en/addr/data   RAM read port (data one cycle after rd_en)
//   ram_wr_en/addr/data   RAM write port
//   ir_enable             high in RUN
//   pass_done             one-cycle pulse in DONE
// -----------------------------------------------------------------------------
module nabp_image_ram_arbiter
  import nabp_image_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = kImageAddressLength,
  parameter int DATA_W  = kCacheDataLength
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ir_kick,
  input  logic                      ir_done,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_val,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ram_rd_en,
  output logic [ADDR_W-1:0]         ram_rd_addr,
  input  logic [DATA_W-1:0]         ram_rd_data,
  output logic                      ram_wr_en,
  output logic [ADDR_W-1:0]         ram_wr_addr,
  output logic [DATA_W-1:0]         ram_wr_data,
  output logic                      ir_enable,
  output logic                      pass_done
);

  state_e state_q;
  state_e state_d;

  logic [ADDR_W-1:0] lane_addr [NUM_REQ];
  logic [DATA_W-1:0] lane_val  [NUM_REQ];

  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [DATA_W-1:0]  gnt_val;
  logic               accept;

  // Stage 1: request granted in the previous cycle, RAM data now valid.
  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [DATA_W-1:0] s1_val_q;

  // Last write: what stage 1 wrote in the previous cycle.
  logic              lw_valid_q;
  logic [ADDR_W-1:0] lw_addr_q;
  logic [DATA_W-1:0] lw_data_q;

  logic               fwd;
  logic [DATA_W-1:0]  base;
  logic signed [63:0] sum_wide;
  logic [DATA_W-1:0]  sum;
  logic               unused_sum_hi;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign lane_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign lane_val[gi]  = req_val[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // The ir_done cycle accepts nothing, so DRAIN only has to retire what was
  // granted before it.
  assign accept = (state_q == ST_RUN) && !ir_done;

  nabp_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (accept),
    .req_i   (req_valid),
    .gnt_o   (gnt)
  );

  assign req_ready = gnt;
  assign gnt_any   = |gnt;

  // One-hot grant: OR of the gated lanes selects the winner (all zero if none).
  always_comb begin
    gnt_addr = '0;
    gnt_val  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_addr = gnt_addr | lane_addr[i];
        gnt_val  = gnt_val  | lane_val[i];
      end
    end
  end

  // The RAM is read-first, so a read issued in the same cycle as the write to
  // that address returns stale data; take the value just written instead.
  assign fwd      = lw_valid_q && (lw_addr_q == s1_addr_q);
  assign base     = fwd ? lw_data_q : ram_rd_data;
  assign sum_wide = sat_add({{(64-DATA_W){base[DATA_W-1]}}, base},
                            {{(64-DATA_W){s1_val_q[DATA_W-1]}}, s1_val_q},
                            DATA_W);
  assign sum           = sum_wide[DATA_W-1:0];
  assign unused_sum_hi = ^sum_wide[63:DATA_W];

`ifdef NABP_IMAGE_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [ADDR_W-1:0] clr_cnt_d;

  assign clr_cnt_d = (state_q == ST_CLEAR) ? clr_cnt_q + ADDR_W'(1) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt_q <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        // A simultaneous ir_done is simply not looked at here.
        if (ir_kick) begin
`ifdef NABP_IMAGE_CLEAR_EN
          state_d = ST_CLEAR;
`else
          state_d = ST_RUN;
`endif
        end
      end
`ifdef NABP_IMAGE_CLEAR_EN
      ST_CLEAR: begin
        if (clr_cnt_q == '1) begin
          state_d = ST_RUN;
        end
      end
`endif
      ST_RUN: begin
        if (ir_done) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ram_rd_en   = gnt_any;
    ram_rd_addr = gnt_addr;
    ram_wr_en   = s1_valid_q;
    ram_wr_addr = s1_valid_q ? s1_addr_q : '0;
    ram_wr_data = s1_valid_q ? sum : '0;
`ifdef NABP_IMAGE_CLEAR_EN
    // Stage 1 is always empty in CLEAR, so the write port is free.
    if (state_q == ST_CLEAR) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = clr_cnt_q;
      ram_wr_data = '0;
    end
`endif
  end

  assign ir_enable = (state_q == ST_RUN);
  assign pass_done = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_val_q   <= '0;
      lw_valid_q <= 1'b0;
      lw_addr_q  <= '0;
      lw_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= gnt_any;
      if (gnt_any) begin
        s1_addr_q <= gnt_addr;
        s1_val_q  <= gnt_val;
      end
      lw_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        lw_addr_q <= s1_addr_q;
        lw_data_q <= sum;
      end
    end
  end

endmodule

// File: tb/tb_nabp_image_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nabp_image_ram_arbiter
// Drives the arbiter against a read-first RAM model. Expected writes are
// pushed to a scoreboard when a grant is expected and popped on the cycle the
// write is due. Grant patterns come from a hand-derived vector table.
// -----------------------------------------------------------------------------
module tb_nabp_image_ram_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ir_kick = 1'b0;
  logic ir_done = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_val;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      ram_rd_en;
  logic [ADDR_W-1:0]         ram_rd_addr;
  logic [DATA_W-1:0]         ram_rd_data = '0;
  logic                      ram_wr_en;
  logic [ADDR_W-1:0]         ram_wr_addr;
  logic [DATA_W-1:0]         ram_wr_data;
  logic                      ir_enable;
  logic                      pass_done;

  logic [ADDR_W-1:0] lane_addr [NUM_REQ];
  logic [DATA_W-1:0] lane_val  [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pack
      assign req_addr[gi*ADDR_W +: ADDR_W] = lane_addr[gi];
      assign req_val[gi*DATA_W +: DATA_W]  = lane_val[gi];
    end
  endgenerate

  always #5 clk = ~clk;

  nabp_image_ram_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ir_kick     (ir_kick),
    .ir_done     (ir_done),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_val     (req_val),
    .req_ready   (req_ready),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ir_enable   (ir_enable),
    .pass_done   (pass_done)
  );

  // Read-first RAM with one-cycle read latency, plus a preload port.
  logic [DATA_W-1:0] ram [DEPTH] = '{default: '0};
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    if (pl_en)     ram[pl_addr] <= pl_data;
  end

  typedef struct {
    int                due;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  typedef struct {
    logic [NUM_REQ-1:0] valid;
    logic [NUM_REQ-1:0] ready;
  } vec_t;

  exp_t sb[$];
  vec_t tbl [12];
  logic [DATA_W-1:0] model [DEPTH];
  int  checks = 0;
  int  passes = 0;
  int  cyc = 0;
  bit  clearing = 1'b0;

  function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Called #1 after a negedge: checks the write scoreboard for this cycle.
  task automatic settle();
    exp_t e;
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("wr_en", {63'd0, ram_wr_en}, 64'd1);
      chk("wr_addr", {56'd0, ram_wr_addr}, {56'd0, e.addr});
      chk("wr_data", {48'd0, ram_wr_data}, {48'd0, e.data});
      $display("txn cyc=%0d write addr=%h data=%h (want %h)", cyc, ram_wr_addr, ram_wr_data, e.data);
    end else if (!clearing) begin
      chk("no_stray_write", {63'd0, ram_wr_en}, 64'd0);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    cyc++;
  endtask

  task automatic expect_cycle(input logic [NUM_REQ-1:0] exp_rdy, input string tag);
    exp_t e;
    settle();
    chk({tag, "_ready"}, {60'd0, req_ready}, {60'd0, exp_rdy});
    chk({tag, "_rd_en"}, {63'd0, ram_rd_en}, {63'd0, |exp_rdy});
    for (int i = 0; i < NUM_REQ; i++) begin
      if (exp_rdy[i]) begin
        chk({tag, "_rd_addr"}, {56'd0, ram_rd_addr}, {56'd0, lane_addr[i]});
        e.due  = cyc + 1;
        e.addr = lane_addr[i];
        e.data = sat16(model[lane_addr[i]], lane_val[i]);
        model[lane_addr[i]] = e.data;
        sb.push_back(e);
      end
    end
    nxt();
  endtask

  task automatic one_lane(input int i, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] v, input string tag);
    logic [NUM_REQ-1:0] m;
    m = 4'b0001 << i;
    req_valid    = m;
    lane_addr[i] = a;
    lane_val[i]  = v;
    expect_cycle(m, tag);
    req_valid = '0;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    model[a] = d;
    settle();
    nxt();
    pl_en = 1'b0;
  endtask

  task automatic do_kick(input logic with_done);
    ir_kick = 1'b1;
    ir_done = with_done;
    settle();
    chk("kick_cycle_enable", {63'd0, ir_enable}, 64'd0);
    nxt();
    ir_kick = 1'b0;
    ir_done = 1'b0;
`ifdef NABP_IMAGE_CLEAR_EN
    clearing = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      settle();
      chk("clr_wr_en", {63'd0, ram_wr_en}, 64'd1);
      chk("clr_wr_addr", {56'd0, ram_wr_addr}, 64'(k));
      chk("clr_wr_data", {48'd0, ram_wr_data}, 64'd0);
      chk("clr_enable", {63'd0, ir_enable}, 64'd0);
      nxt();
    end
    clearing = 1'b0;
    for (int k = 0; k < DEPTH; k++) model[k] = '0;
`endif
    settle();
    chk("enable_rise", {63'd0, ir_enable}, 64'd1);
    nxt();
  endtask

  task automatic finish_pass();
    ir_done = 1'b1;
    settle();
    chk("done_cycle_ready", {60'd0, req_ready}, 64'd0);
    chk("done_cycle_rd_en", {63'd0, ram_rd_en}, 64'd0);
    chk("done_cycle_enable", {63'd0, ir_enable}, 64'd1);
    nxt();
    ir_done   = 1'b0;
    req_valid = '0;
    settle();
    chk("drain_enable", {63'd0, ir_enable}, 64'd0);
    chk("drain_pass_done", {63'd0, pass_done}, 64'd0);
    nxt();
    settle();
    chk("pass_done", {63'd0, pass_done}, 64'd1);
    nxt();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) model[k] = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      lane_addr[i] = '0;
      lane_val[i]  = '0;
    end
    // Grant sequence from rr = 0, derived by hand.
    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001};
    tbl[5]  = '{4'b0001, 4'b0001};
    tbl[6]  = '{4'b0000, 4'b0000};
    tbl[7]  = '{4'b1001, 4'b1000};
    tbl[8]  = '{4'b0110, 4'b0010};
    tbl[9]  = '{4'b0110, 4'b0100};
    tbl[10] = '{4'b0011, 4'b0001};
    tbl[11] = '{4'b0011, 4'b0010};

    // Reset state.
    @(negedge clk);
    settle();
    chk("reset_outputs", {24'd0, req_ready, ram_rd_en, ram_rd_addr, ram_wr_en,
                          ram_wr_addr, ram_wr_data, ir_enable, pass_done}, 64'd0);
    nxt();
    reset_n = 1'b1;
    req_valid = 4'b1111;
    settle();
    chk("idle_ready", {60'd0, req_ready}, 64'd0);
    chk("idle_enable", {63'd0, ir_enable}, 64'd0);
    nxt();
    req_valid = '0;

    // Pass 1: round robin table.
    do_kick(1'b0);
    for (int v = 0; v < 12; v++) begin
      req_valid = tbl[v].valid;
      for (int i = 0; i < NUM_REQ; i++) begin
        lane_addr[i] = 8'h40 + 8'(v * 4 + i);
        lane_val[i]  = 16'(v + i + 1);
      end
      expect_cycle(tbl[v].ready, $sformatf("rr_vec%0d", v));
    end
    req_valid = '0;

    // Same-address hazard and saturation (rr = 2 here).
    preload(8'h10, 16'h0003);
    preload(8'h20, 16'h7FF0);
    preload(8'h21, 16'h8005);
    one_lane(0, 8'h10, 16'h0005, "haz_a");
    one_lane(1, 8'h10, 16'h0007, "haz_b");
    one_lane(2, 8'h20, 16'h0020, "sat_pos");
    one_lane(3, 8'h21, 16'hFFF0, "sat_neg");
    one_lane(0, 8'h30, 16'h3000, "rep_a");
    one_lane(1, 8'h30, 16'h3000, "rep_b");
    one_lane(2, 8'h30, 16'h3000, "rep_c");

    // End of pass, with a kick in DRAIN that must be ignored.
    req_valid    = 4'b1000;
    lane_addr[3] = 8'h31;
    ir_done      = 1'b1;
    settle();
    chk("done_cycle_ready", {60'd0, req_ready}, 64'd0);
    chk("done_cycle_enable", {63'd0, ir_enable}, 64'd1);
    nxt();
    ir_done   = 1'b0;
    req_valid = '0;
    ir_kick   = 1'b1;
    settle();
    chk("drain_enable", {63'd0, ir_enable}, 64'd0);
    chk("drain_pass_done", {63'd0, pass_done}, 64'd0);
    nxt();
    ir_kick = 1'b0;
    settle();
    chk("pass_done", {63'd0, pass_done}, 64'd1);
    nxt();
    settle();
    chk("idle_pass_done", {63'd0, pass_done}, 64'd0);
    chk("drain_kick_ignored", {63'd0, ir_enable}, 64'd0);
    nxt();

    // Pass 2: kick and done together in IDLE, then abort by reset.
    do_kick(1'b1);
    settle();
    chk("kick_done_dropped", {63'd0, ir_enable}, 64'd1);
    chk("kick_done_no_pass", {63'd0, pass_done}, 64'd0);
    nxt();
    one_lane(3, 8'h60, 16'h0001, "p2_a");
    one_lane(0, 8'h61, 16'h0002, "p2_b");
    one_lane(1, 8'h62, 16'h0003, "p2_c");
    one_lane(2, 8'h50, 16'h0009, "p2_abort");
    req_valid = 4'b0100;
    reset_n   = 1'b0;
    sb.delete();
    settle();
    chk("abort_outputs", {24'd0, req_ready, ram_rd_en, ram_rd_addr, ram_wr_en,
                          ram_wr_addr, ram_wr_data, ir_enable, pass_done}, 64'd0);
    nxt();
    settle();
    chk("abort_no_pass_done", {63'd0, pass_done}, 64'd0);
    nxt();
    reset_n   = 1'b1;
    req_valid = '0;
    settle();
    chk("abort_idle_enable", {63'd0, ir_enable}, 64'd0);
    chk("abort_idle_pass_done", {63'd0, pass_done}, 64'd0);
    nxt();

    // Pass 3: clean restart, pointer back at lane 0.
    do_kick(1'b0);
    req_valid = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) begin
      lane_addr[i] = 8'h70 + 8'(i);
      lane_val[i]  = 16'(i + 1);
    end
    expect_cycle(4'b0001, "p3_a");
    expect_cycle(4'b0010, "p3_b");
    finish_pass();
    settle();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
